sb_tx_serializer: RTL and testbench

- Parametrised sideband transmit serializer; next generation of the single-lane, fixed-64-bit sideband TX path.
- Buffers sideband words from the LTSM/encoder side through a valid/ready FIFO.
- Serialises each word over LANES data pins, LSB-first, followed by a programmable idle gap (UCIe 64 UI + 32 UI low framing at the defaults).
- Provides a clock-gate enable for an external ICG, plus flush, status and sent-pulse outputs, all in one clock domain.

---
 rtl/sb_tx_pkg.sv | 18 +
 rtl/sb_tx_fifo.sv | 53 +++++
 rtl/sb_tx_serializer.sv | 142 ++++++++++++++
 tb/tb_sb_tx_serializer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_tx_pkg.sv
// Shared types and defaults for the sideband transmit serializer.
package sb_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX   = 2'd1,
    GAP  = 2'd2
  } sb_tx_state_t;

  localparam int unsigned SB_MSG_WIDTH = 64;
  localparam int unsigned SB_GAP_UI    = 32;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int unsigned min1_clog2(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/sb_tx_fifo.sv
// Synchronous word FIFO with registered count and synchronous flush.
module sb_tx_fifo
  import sb_tx_pkg::*;
#(
  parameter int unsigned WIDTH = SB_MSG_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [WIDTH-1:0]           head_o
);

  localparam int unsigned AW = min1_clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      count_q <= count_q + 1'b1;
      else if (pop_i && !push_i) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: FIFO-buffered words sent LSB-first over LANES pins,
// each followed by a fixed low gap; drives an external clock-gate enable.
module sb_tx_serializer
  import sb_tx_pkg::*;
#(
  parameter int unsigned MSG_WIDTH  = SB_MSG_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LANES      = 1,
  parameter int unsigned GAP_CYCLES = SB_GAP_UI
) (
  input  logic                          clk_800MHz,
  input  logic                          reset,
  input  logic                          enable_i,
  input  logic                          flush_i,
  input  logic [MSG_WIDTH-1:0]          data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [LANES-1:0]              data_o,
  output logic                          clk_gate_o,
  output logic                          busy_o,
  output logic                          word_sent_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int unsigned BEATS = MSG_WIDTH / LANES;
  localparam int unsigned BW    = min1_clog2(BEATS);
  localparam int unsigned GW    = min1_clog2(GAP_CYCLES);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [GW-1:0] LAST_GAP  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  if ((MSG_WIDTH % LANES) != 0) begin : g_bad_width
    $error("sb_tx_serializer: MSG_WIDTH must be a multiple of LANES");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sb_tx_serializer: FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
    $error("sb_tx_serializer: LANES must be 1, 2, 4 or 8");
  end

  sb_tx_state_t           state_q, state_d;
  logic [MSG_WIDTH-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [GW-1:0]          gap_q, gap_d;

  logic                   fifo_full, fifo_empty, push, pop, can_pop, load, word_done;
  logic [MSG_WIDTH-1:0]   fifo_head;

  assign ready_o = !reset && enable_i && !fifo_full && !flush_i;
  assign push    = valid_i && ready_o;
  // Flush suppresses any pop at the same edge so the block falls back to IDLE.
  assign can_pop = !fifo_empty && !flush_i;

  sb_tx_fifo #(
    .WIDTH (MSG_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_800MHz),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush_i),
    .data_i  (data_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o),
    .head_o  (fifo_head)
  );

  always_ff @(posedge clk_800MHz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      beat_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    beat_d      = beat_q;
    gap_d       = gap_q;
    pop         = 1'b0;
    load        = 1'b0;
    word_done   = 1'b0;
    data_o      = '0;
    clk_gate_o  = 1'b0;
    word_sent_o = 1'b0;

    case (state_q)
      IDLE: begin
        load = can_pop;
      end
      TX: begin
        data_o     = shreg_q[beat_q*LANES +: LANES];
        clk_gate_o = 1'b1;
        if (beat_q == LAST_BEAT) begin
          word_sent_o = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            beat_d  = '0;
            gap_d   = '0;
          end else begin
            word_done = 1'b1;
          end
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == LAST_GAP) word_done = 1'b1;
        else                   gap_d     = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // End of a word's slot (gap exit, or last beat when there is no gap).
    if (word_done) begin
      state_d = IDLE;
      beat_d  = '0;
      gap_d   = '0;
      load    = can_pop;
    end

    if (load) begin
      pop     = 1'b1;
      shreg_d = fifo_head;
      beat_d  = '0;
      gap_d   = '0;
      state_d = TX;
    end
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Randomized bench for two serializer configurations against a slot-based word model.
module tb_sb_tx_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en [2];
  logic        fl [2];
  logic        vld [2];
  logic [63:0] dat [2];

  logic [1:0]  rdy_w, gate_w, busy_w, sent_w;
  logic [2:0]  cnt0, cnt1;
  logic [0:0]  d0;
  logic [3:0]  d1;

  always #5 clk = ~clk;

  sb_tx_serializer #(
    .MSG_WIDTH (64), .FIFO_DEPTH (4), .LANES (1), .GAP_CYCLES (32)
  ) dut0 (
    .clk_800MHz (clk), .reset (reset), .enable_i (en[0]), .flush_i (fl[0]),
    .data_i (dat[0]), .valid_i (vld[0]), .ready_o (rdy_w[0]), .data_o (d0),
    .clk_gate_o (gate_w[0]), .busy_o (busy_w[0]), .word_sent_o (sent_w[0]),
    .fifo_count_o (cnt0)
  );

  sb_tx_serializer #(
    .MSG_WIDTH (64), .FIFO_DEPTH (4), .LANES (4), .GAP_CYCLES (0)
  ) dut1 (
    .clk_800MHz (clk), .reset (reset), .enable_i (en[1]), .flush_i (fl[1]),
    .data_i (dat[1]), .valid_i (vld[1]), .ready_o (rdy_w[1]), .data_o (d1),
    .clk_gate_o (gate_w[1]), .busy_o (busy_w[1]), .word_sent_o (sent_w[1]),
    .fifo_count_o (cnt1)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a word occupies a slot of BEATS data cycles plus GAP low cycles;
  // the next word starts right after its slot if one is waiting.
  logic [63:0] mq [2][4];
  int          mhead [2], mcnt [2], pos [2];
  bit          act [2], rdy_m [2], acc [2], flush_once [2];
  logic [63:0] cw [2];
  logic [63:0] src0 [$], src1 [$];
  int          gate_cnt [2], sent_cnt [2], max_cnt [2];
  int          p_valid = 0, p_flush = 0, p_dis = 0;
  logic        en_force = 1'b1;

  function automatic int lanes_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction
  function automatic int gap_of(input int i);
    return (i == 0) ? 32 : 0;
  endfunction

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      gate_cnt[i] = 0; sent_cnt[i] = 0; max_cnt[i] = 0;
    end
  endtask

  task automatic drive();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) vld[i] = 1'b0;
      acc[i] = 1'b0;
      if (!vld[i]) begin
        if (i == 0 && src0.size() > 0) begin
          vld[i] = 1'b1; dat[i] = src0.pop_front();
        end else if (i == 1 && src1.size() > 0) begin
          vld[i] = 1'b1; dat[i] = src1.pop_front();
        end else if ($urandom_range(0, 99) < p_valid) begin
          vld[i] = 1'b1; dat[i] = {$urandom, $urandom};
        end
      end
      fl[i] = flush_once[i] || ($urandom_range(0, 99) < p_flush);
      flush_once[i] = 1'b0;
      en[i] = (p_dis > 0) ? ($urandom_range(0, 99) >= p_dis) : en_force;
    end
  endtask

  task automatic check_all();
    int          L, B;
    logic [63:0] ed, od, oc;
    logic        eg, es;
    #1;
    for (int i = 0; i < 2; i++) begin
      L  = lanes_of(i);
      B  = 64 / L;
      rdy_m[i] = en[i] && !fl[i] && (mcnt[i] < 4) && !reset;
      eg = act[i] && (pos[i] < B);
      es = act[i] && (pos[i] == B - 1);
      ed = eg ? ((cw[i] >> (pos[i] * L)) & ((64'd1 << L) - 64'd1)) : 64'd0;
      od = (i == 0) ? {63'd0, d0} : {60'd0, d1};
      oc = (i == 0) ? {61'd0, cnt0} : {61'd0, cnt1};
      check($sformatf("data%0d", i),  od, ed);
      check($sformatf("gate%0d", i),  {63'd0, gate_w[i]}, {63'd0, eg});
      check($sformatf("sent%0d", i),  {63'd0, sent_w[i]}, {63'd0, es});
      check($sformatf("busy%0d", i),  {63'd0, busy_w[i]}, {63'd0, act[i]});
      check($sformatf("ready%0d", i), {63'd0, rdy_w[i]}, {63'd0, rdy_m[i]});
      check($sformatf("count%0d", i), oc, 64'(mcnt[i]));
      gate_cnt[i] += int'(gate_w[i]);
      sent_cnt[i] += int'(sent_w[i]);
      if (int'(oc) > max_cnt[i]) max_cnt[i] = int'(oc);
    end
  endtask

  task automatic update_all();
    int B;
    for (int i = 0; i < 2; i++) begin
      B = 64 / lanes_of(i);
      acc[i] = vld[i] && rdy_m[i];
      if (act[i]) begin
        pos[i]++;
        if (pos[i] == B + gap_of(i)) act[i] = 1'b0;
      end
      if (!act[i] && mcnt[i] > 0 && !fl[i]) begin
        cw[i]    = mq[i][mhead[i]];
        mhead[i] = (mhead[i] + 1) % 4;
        mcnt[i]--;
        act[i]   = 1'b1;
        pos[i]   = 0;
      end
      if (acc[i]) begin
        mq[i][(mhead[i] + mcnt[i]) % 4] = dat[i];
        mcnt[i]++;
      end
      if (fl[i]) begin
        mcnt[i]  = 0;
        mhead[i] = 0;
      end
    end
  endtask

  task automatic cycle();
    drive();
    check_all();
    @(posedge clk);
    update_all();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; pos[i] = 0; mcnt[i] = 0; mhead[i] = 0;
      acc[i] = 1'b0; vld[i] = 1'b0; fl[i] = 1'b0; flush_once[i] = 1'b0;
      cw[i] = '0;
    end
    src0.delete();
    src1.delete();
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; fl[i] = 1'b0; en[i] = 1'b1; acc[i] = 1'b0;
    end
    check_all();
    check("ready_after_rst", {63'd0, rdy_w[0]}, {63'd0, en[0]});
    @(posedge clk);
    update_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data0"}, {63'd0, d0}, 64'd0);
    check({tag, "_data1"}, {60'd0, d1}, 64'd0);
    check({tag, "_gate"},  {62'd0, gate_w}, 64'd0);
    check({tag, "_busy"},  {62'd0, busy_w}, 64'd0);
    check({tag, "_ready"}, {62'd0, rdy_w}, 64'd0);
    check({tag, "_sent"},  {62'd0, sent_w}, 64'd0);
    check({tag, "_count"}, {58'd0, cnt0, cnt1}, 64'd0);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b1; dat[i] = '0;
    end
    #3;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    release_reset();

    // Single default word, plus two words on the 4-lane no-gap instance.
    clear_stats();
    src0.push_back(64'hA5A5_0000_FFFF_1234);
    src1.push_back({$urandom, $urandom});
    src1.push_back({$urandom, $urandom});
    run(120);
    check("single_gate_cycles0", 64'(gate_cnt[0]), 64'd64);
    check("single_sent0", 64'(sent_cnt[0]), 64'd1);
    check("single_gate_cycles1", 64'(gate_cnt[1]), 64'd32);
    check("single_sent1", 64'(sent_cnt[1]), 64'd2);

    // Five back-to-back words into a depth-4 FIFO.
    clear_stats();
    for (int k = 0; k < 5; k++) begin
      src0.push_back({$urandom, $urandom});
      src1.push_back({$urandom, $urandom});
    end
    run(520);
    check("burst_max_count0", 64'(max_cnt[0]), 64'd4);
    check("burst_sent0", 64'(sent_cnt[0]), 64'd5);
    check("burst_sent1", 64'(sent_cnt[1]), 64'd5);

    // Flush during beat 10 of the first of three queued words.
    clear_stats();
    for (int k = 0; k < 3; k++) src0.push_back({$urandom, $urandom});
    for (int k = 0; k < 100 && !(act[0] && pos[0] == 10); k++) cycle();
    check("flush_reached_beat10", {63'd0, act[0] && pos[0] == 10}, 64'd1);
    flush_once[0] = 1'b1;
    run(150);
    check("flush_sent0", 64'(sent_cnt[0]), 64'd1);
    check("flush_count0", {61'd0, cnt0}, 64'd0);

    // Asynchronous reset in the middle of a word.
    src0.push_back({$urandom, $urandom});
    for (int k = 0; k < 100 && !(act[0] && pos[0] == 20); k++) cycle();
    check("rst_reached_beat20", {63'd0, act[0] && pos[0] == 20}, 64'd1);
    check("rst_pre_gate", {63'd0, gate_w[0]}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("midword");
    model_reset();
    repeat (2) @(posedge clk);
    release_reset();

    // Drop enable with words queued: they still drain, nothing new is accepted.
    clear_stats();
    for (int k = 0; k < 3; k++) begin
      src0.push_back({$urandom, $urandom});
      src1.push_back({$urandom, $urandom});
    end
    run(4);
    en_force = 1'b0;
    src0.push_back({$urandom, $urandom});
    run(400);
    check("endrop_sent0", 64'(sent_cnt[0]), 64'd3);
    check("endrop_sent1", 64'(sent_cnt[1]), 64'd3);
    check("endrop_pending", {63'd0, vld[0]}, 64'd1);
    en_force = 1'b1;
    run(120);
    check("reenable_sent0", 64'(sent_cnt[0]), 64'd4);

    // Random traffic with occasional flushes and enable drops.
    p_valid = 30; p_flush = 2; p_dis = 10;
    run(3000);
    p_valid = 0; p_flush = 0; p_dis = 0;
    run(600);
    check("drain_idle", {62'd0, busy_w}, 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
